// File: rtl/rom_loader_pkg.sv
// Shared defaults and FSM state encoding for the sequential ROM loader.
package rom_loader_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DB_CYCLES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Operator-facing bundle of the loader: buttons, switches and display/status outputs.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              btn_wr;
  logic              btn_clr;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic              busy;
  logic              err;

  // The master is the operator panel; the slave is the loader itself.
  modport master (
    output btn_wr, btn_clr, din, rd_addr,
    input  rd_data, wr_ptr, full, busy, err
  );

  modport slave (
    input  btn_wr, btn_clr, din, rd_addr,
    output rd_data, wr_ptr, full, busy, err
  );

endinterface

// File: rtl/rom_loader_button_conditioner.sv
// Raw pushbutton to one-cycle press pulse: 2-flop synchronizer, debounce, rising-edge detect.
module button_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int                CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      level_d <= level_q;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync_q2 == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= sync_q2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level_q & ~level_d;

endmodule

// File: rtl/rom_loader.sv
// Writable memory filled byte-by-byte from a write button, swept to zero by a clear button.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  rom_loader_if.slave  io
);

  localparam int DEPTH = 1 << ADDR_W;

  logic wr_press;
  logic clr_press;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_wr_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (io.btn_wr),
    .press   (wr_press)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clr_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (io.btn_clr),
    .press   (clr_press)
  );

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              full_q,    full_d;
  logic              err_q,     err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      clr_idx_q <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      clr_idx_q <= clr_idx_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    clr_idx_d = clr_idx_q;
    full_d    = full_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = io.din;

    case (state_q)
      IDLE: begin
        // Clear outranks a coincident write, and that write is dropped silently.
        if (clr_press) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (wr_press) begin
          if (full_q) begin
            err_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
              full_d = 1'b1;
            end
          end
        end
      end

      CLEAR: begin
        err_d     = wr_press;
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          full_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register resets.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read sees the pre-write contents when addresses collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[io.rd_addr];
    end
  end

  assign io.rd_data = rd_data_q;
  assign io.wr_ptr  = wr_ptr_q;
  assign io.full    = full_q;
  assign io.busy    = (state_q == CLEAR);
  assign io.err     = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a cycle-stepped behavioural model of the loader.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DB    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rom_loader_if #(.ADDR_W(AW), .DATA_W(DW)) io ();

  rom_loader #(.ADDR_W(AW), .DATA_W(DW), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, next write slot, status flags, sweep progress.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr   = 0;
  bit            m_full  = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_err   = 1'b0;
  int            m_idx   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("wr_ptr", 32'(io.wr_ptr), 32'(m_ptr));
    check("full",   32'(io.full),   32'(m_full));
    check("busy",   32'(io.busy),   32'(m_busy));
    check("err",    32'(io.err),    32'(m_err));
  endtask

  // One clock: wr/clr say whether a conditioned press pulse is due on this edge.
  task automatic tick(input bit wr, input bit clr);
    @(posedge clk);
    m_err = 1'b0;
    if (m_busy) begin
      if (wr) m_err = 1'b1;
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) begin
        m_busy = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
      end
    end else if (clr) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (wr) begin
      if (m_full) begin
        m_err = 1'b1;
      end else begin
        m_mem[m_ptr] = io.din;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_ptr == 0) m_full = 1'b1;
      end
    end
    @(negedge clk);
    check_status();
  endtask

  // Clean press: pulse lands 2 sync + DB debounce + 1 edge after the raw rise.
  task automatic press(input bit wr, input bit clr, input int hold);
    io.btn_wr  = wr;
    io.btn_clr = clr;
    repeat (DB + 2) tick(1'b0, 1'b0);
    tick(wr, clr);
    repeat (hold) tick(1'b0, 1'b0);
    io.btn_wr  = 1'b0;
    io.btn_clr = 1'b0;
    repeat (DB + 3) tick(1'b0, 1'b0);
  endtask

  task automatic write_byte(input logic [DW-1:0] value);
    io.din = value;
    press(1'b1, 1'b0, $urandom_range(1, 4));
  endtask

  task automatic read_check(input int addr);
    logic [DW-1:0] exp;
    io.rd_addr = AW'(addr);
    exp = m_mem[addr];
    tick(1'b0, 1'b0);
    check($sformatf("rd_data[%0d]", addr), 32'(io.rd_data), 32'(exp));
  endtask

  task automatic read_all();
    int start;
    start = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) read_check((start + i) % DEPTH);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_ptr  = 0;
    m_full = 1'b0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_idx  = 0;
    check_status();
    check("rst rd_data", 32'(io.rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    io.btn_wr  = 1'b0;
    io.btn_clr = 1'b0;
    io.din     = '0;
    io.rd_addr = '0;
    @(negedge clk);
    do_reset();
    repeat (2) tick(1'b0, 1'b0);

    // Three fixed writes, then read back through the registered port.
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    check("ptr after 3", 32'(io.wr_ptr), 32'd3);
    read_check(1);
    read_check(0);
    read_check(2);

    // Bounce: three 3-sample highs separated by 1-sample lows, then a stable press.
    io.din = 8'($urandom);
    for (int b = 0; b < 3; b++) begin
      io.btn_wr = 1'b1;
      repeat (3) tick(1'b0, 1'b0);
      io.btn_wr = 1'b0;
      tick(1'b0, 1'b0);
    end
    press(1'b1, 1'b0, 2);
    check("ptr after bounce", 32'(io.wr_ptr), 32'd4);
    read_check(3);

    // Fill to the wrap point, then an overflow press must be rejected.
    for (int i = 4; i < DEPTH; i++) write_byte(8'($urandom));
    check("full after fill", 32'(io.full), 32'd1);
    write_byte(8'hA5);
    read_check(0);
    read_all();

    // Clear sweep with a write press landing mid-sweep.
    press(1'b0, 1'b1, 2);
    io.din = 8'hEE;
    press(1'b1, 1'b0, 2);
    repeat (DEPTH) tick(1'b0, 1'b0);
    read_all();

    // Simultaneous presses: clear wins, no write, no error.
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    io.din = 8'h77;
    press(1'b1, 1'b1, 2);
    repeat (DEPTH) tick(1'b0, 1'b0);
    read_all();

    // Refill with random data, then reset ten cycles into a clear sweep.
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    io.btn_clr = 1'b1;
    repeat (DB + 2) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    io.btn_clr = 1'b0;
    repeat (8) tick(1'b0, 1'b0);
    do_reset();
    repeat (DB + 3) tick(1'b0, 1'b0);
    read_all();

    // Random spot reads and a post-reset write.
    for (int i = 0; i < 8; i++) read_check($urandom_range(0, DEPTH - 1));
    write_byte(8'($urandom));
    read_check(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
